// File: rtl/instr_mem_loader.sv
// Instruction RAM with byte-stream boot loader and combinational fetch.
// Holds the core in reset while loading, releases it in RUN.
module instr_mem_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [31:0] NOP    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [31:0]       PC,
    output logic [31:0]       Instr,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              addr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamp;
    logic [ADDR_W:0]   wr_cnt_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [1:0]        byte_cnt;
    logic [31:0]       shift_q;
    logic [31:0]       word_nx;
    logic [31:0]       mem [DEPTH];
    logic              xfer;
    logic              word_done;
    logic              last_word;
    logic              fetch_ok;

    assign len_clamp = load_len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : load_len;

    assign xfer      = byte_valid && (state == LOAD);
    assign word_nx   = {byte_in, shift_q[31:8]};
    assign word_done = xfer && (byte_cnt == 2'd3);
    assign wr_cnt_nx = {1'b0, wr_ptr} + (ADDR_W+1)'(1);
    assign last_word = word_done && (wr_cnt_nx == len_q);

    assign byte_ready = (state == LOAD);
    assign cpu_rst    = (state == RUN);
    assign load_done  = (state == RUN);

    assign fetch_ok = (state == RUN) && (PC[1:0] == 2'b00) &&
                      (PC[31:ADDR_W+2] == '0);
    assign Instr    = fetch_ok ? mem[PC[ADDR_W+1:2]] : NOP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, RUN: begin
                if (load_start) state_nx = (load_len == '0) ? RUN : LOAD;
            end
            LOAD: begin
                if (load_start) state_nx = (load_len == '0) ? RUN : LOAD;
                else if (last_word) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // load_start wins over a byte landing on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            wr_ptr   <= '0;
            byte_cnt <= '0;
            shift_q  <= '0;
            addr_err <= 1'b0;
        end else if (load_start) begin
            len_q    <= len_clamp;
            wr_ptr   <= '0;
            byte_cnt <= '0;
            addr_err <= 1'b0;
        end else begin
            if (xfer) begin
                shift_q  <= word_nx;
                byte_cnt <= byte_cnt + 2'd1;
                if (word_done) wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if ((state == RUN) && !fetch_ok) addr_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (word_done && !load_start) mem[wr_ptr] <= word_nx;
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a word-level RAM model.
// Loads are driven as byte streams; fetches are checked combinationally.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [8:0]  load_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        cpu_rst;
    logic        load_done;
    logic        addr_err;

    int checks;
    int failures;

    logic [7:0]  bq      [1024];
    logic [31:0] ref_mem [256];
    bit          known   [256];

    instr_mem_loader #(
        .ADDR_W(8),
        .NOP(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_start(load_start),
        .load_len(load_len),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .PC(PC),
        .Instr(Instr),
        .cpu_rst(cpu_rst),
        .load_done(load_done),
        .addr_err(addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rand_bytes(input int n);
        for (int i = 0; i < n; i++) bq[i] = 8'($urandom);
    endtask

    // Streams min(len,256)*4 bytes from bq; pat selects a 1,0,0,1 valid rhythm.
    task automatic do_load(input int len, input bit pat);
        int n;
        int idx;
        int acc;
        int cyc;
        bit v;
        n   = ((len > 256) ? 256 : len) * 4;
        idx = 0;
        acc = 0;
        cyc = 0;
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 9'(len);
        @(negedge clk);
        load_start = 1'b0;
        check("addr_err_clr", 32'(addr_err), 32'd0);
        if (len != 0) begin
            check("ready_load", 32'(byte_ready), 32'd1);
            check("cpu_held", 32'(cpu_rst), 32'd0);
            check("nop_in_load", Instr, 32'h0);
        end
        while (byte_ready && cyc < 5000) begin
            if (idx >= n) v = 1'b1;
            else if (pat) v = (cyc % 4 == 0) || (cyc % 4 == 3);
            else v = ($urandom_range(0, 2) != 0);
            byte_valid = v;
            byte_in    = (idx < n) ? bq[idx] : 8'hEE;
            if (v) begin
                if (idx == n - 1) check("cpu_rst_pre", 32'(cpu_rst), 32'd0);
                acc++;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        byte_valid = 1'b0;
        check("bytes_accepted", 32'(acc), 32'(n));
        check("load_done", 32'(load_done), 32'd1);
        check("cpu_rst_run", 32'(cpu_rst), 32'd1);
        @(negedge clk);
        check("ready_after", 32'(byte_ready), 32'd0);
        for (int w = 0; w < n / 4; w++) begin
            ref_mem[w] = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
            known[w]   = 1'b1;
        end
    endtask

    task automatic verify_all(input string tag);
        for (int i = 0; i < 256; i++) begin
            if (known[i]) begin
                PC = 32'(i) * 4;
                #1;
                check(tag, Instr, ref_mem[i]);
            end
        end
        PC = 32'h0;
    endtask

    initial begin
        bit exp_err;
        bit ok;
        logic [31:0] pc_r;
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        load_start = 1'b0;
        load_len   = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        PC         = 32'h0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;

        #2;
        check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_instr", Instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_held", 32'(cpu_rst), 32'd0);

        bq[0] = 8'h13; bq[1] = 8'h00; bq[2] = 8'h08; bq[3] = 8'h20;
        bq[4] = 8'h00; bq[5] = 8'h00; bq[6] = 8'h00; bq[7] = 8'h00;
        do_load(2, 1'b0);
        PC = 32'h0;
        #1 check("fetch_pc0", Instr, 32'h2008_0013);
        PC = 32'h4;
        #1 check("fetch_pc4", Instr, 32'h0);
        PC = 32'h0;

        @(negedge clk);
        PC = 32'h0000_0402;
        #1 check("misalign_nop", Instr, 32'h0);
        @(negedge clk);
        PC = 32'h0;
        check("misalign_err", 32'(addr_err), 32'd1);
        @(negedge clk);
        check("err_sticky", 32'(addr_err), 32'd1);

        rand_bytes(12);
        do_load(3, 1'b1);
        verify_all("fetch_pat");

        @(negedge clk);
        PC = 32'h0000_0400;
        #1 check("range_nop", Instr, 32'h0);
        @(negedge clk);
        PC = 32'h0;
        check("range_err", 32'(addr_err), 32'd1);

        rand_bytes(1024);
        do_load(300, 1'b0);
        verify_all("fetch_full");

        exp_err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("rand_err", 32'(addr_err), 32'(exp_err));
            if ($urandom_range(0, 3) != 0) pc_r = 32'($urandom_range(0, 255)) * 4;
            else pc_r = $urandom;
            PC = pc_r;
            ok = (pc_r % 4 == 0) && (pc_r < 1024);
            #1;
            if (!ok) check("rand_nop", Instr, 32'h0);
            else if (known[pc_r / 4]) check("rand_fetch", Instr, ref_mem[pc_r / 4]);
            exp_err = exp_err | !ok;
        end
        @(negedge clk);
        PC = 32'h0;
        check("rand_err_end", 32'(addr_err), 32'(exp_err));

        @(negedge clk);
        load_start = 1'b1;
        load_len   = 9'd2;
        @(negedge clk);
        load_start = 1'b0;
        rand_bytes(6);
        for (int k = 0; k < 6; k++) begin
            byte_valid = 1'b1;
            byte_in    = bq[k];
            @(negedge clk);
        end
        byte_valid = 1'b0;
        ref_mem[0] = {bq[3], bq[2], bq[1], bq[0]};
        rst = 1'b0;
        #1;
        check("midrst_cpu", 32'(cpu_rst), 32'd0);
        check("midrst_ready", 32'(byte_ready), 32'd0);
        check("midrst_done", 32'(load_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_load(0, 1'b0);
        PC = 32'h0;
        #1 check("warm_pc0", Instr, ref_mem[0]);
        verify_all("warm_all");

        for (int r = 0; r < 3; r++) begin
            int len;
            len = $urandom_range(1, 12);
            rand_bytes(len * 4);
            do_load(len, r[0]);
            verify_all("reload");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
